// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- four-slot alarm clock controller.
//
// Compares the running BCD time against four programmable alarm slots. A slot
// fires once when its match begins (rising edge of the match). The first firing
// slot, taken while idle, starts a ring event. The user can stop the event or
// snooze it a limited number of times.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   sec_time     current seconds, BCD
//   min_time     current minutes, BCD
//   hour_time    current hours, BCD
//   wr_en        one-cycle slot write strobe
//   wr_addr      slot index to write
//   wr_data      {hour, min, sec} BCD alarm time
//   wr_enable    slot enable bit, written together with wr_data
//   stop_key     one-cycle pulse that cancels the event
//   snooze_key   one-cycle pulse that snoozes the event
//   led          4'b1111 while ringing; one-hot slot while snoozing; 0 when idle
//   ring         high while ringing
//   active_slot  slot that owns the current (or most recent) event
//   busy         high while ringing or snoozing
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a slot to fire
//   ST_RING   | alarm sounding; cnt counts ring cycles
//   ST_SNOOZE | alarm paused; cnt counts snooze cycles

module alarm_ctrl #(
   parameter int KEEP_TIME   = 50,
   parameter int SNOOZE_TIME = 20,
   parameter int MAX_SNOOZE  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sec_time,
   input  logic [7:0]  min_time,
   input  logic [7:0]  hour_time,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [23:0] wr_data,
   input  logic        wr_enable,
   input  logic        stop_key,
   input  logic        snooze_key,
   output logic [3:0]  led,
   output logic        ring,
   output logic [1:0]  active_slot,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam logic [29:0] RING_LAST   = 30'(KEEP_TIME - 1);
   localparam logic [29:0] SNOOZE_LAST = 30'(SNOOZE_TIME - 1);
   localparam logic [1:0]  SNOOZE_MAX  = 2'(MAX_SNOOZE);

   logic [23:0] slot_time [4];
   logic [3:0]  slot_en;
   logic [23:0] now_time;
   logic [3:0]  hit;
   logic [3:0]  hit_d;
   logic [3:0]  trigger;
   logic [1:0]  first_slot;

   state_t      state;
   state_t      state_nxt;
   logic [29:0] cnt;
   logic [29:0] cnt_nxt;
   logic [1:0]  snooze_cnt;
   logic [1:0]  snooze_cnt_nxt;
   logic [1:0]  slot_sel;
   logic [1:0]  slot_sel_nxt;
   logic        cancel_wr;

   assign now_time = {hour_time, min_time, sec_time};

   // Slot storage. The write lands on the clock edge that samples wr_en, so
   // a comparison in that same cycle still sees the old slot contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            slot_time[i] <= '0;
         end
         slot_en <= '0;
      end else if (wr_en) begin
         slot_time[wr_addr] <= wr_data;
         slot_en[wr_addr]   <= wr_enable;
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < 4; i++) begin
         hit[i] = slot_en[i] && (slot_time[i] == now_time);
      end
   end

   // hit_d tracks hit in every state, so a match that starts while busy is
   // consumed and cannot fire later just because the controller went idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_d <= '0;
      end else begin
         hit_d <= hit;
      end
   end

   assign trigger = hit & ~hit_d;

   // Lowest-index firing slot wins when several fire together.
   always_comb begin
      first_slot = '0;
      for (int i = 3; i >= 0; i--) begin
         if (trigger[i]) begin
            first_slot = 2'(i);
         end
      end
   end

   // Reprogramming the slot that owns the event invalidates that event.
   assign cancel_wr = wr_en && (wr_addr == slot_sel);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         snooze_cnt <= '0;
         slot_sel   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         snooze_cnt <= snooze_cnt_nxt;
         slot_sel   <= slot_sel_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      snooze_cnt_nxt = snooze_cnt;
      slot_sel_nxt   = slot_sel;
      case (state)
         ST_IDLE: begin
            if (trigger != 4'b0000) begin
               state_nxt      = ST_RING;
               slot_sel_nxt   = first_slot;
               cnt_nxt        = '0;
               snooze_cnt_nxt = '0;
            end
         end
         ST_RING: begin
            // stop (or a cancelling write) beats timeout, timeout beats snooze;
            // snooze_cnt is left untouched on the way out.
            if (stop_key || cancel_wr) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == RING_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (snooze_key && (snooze_cnt < SNOOZE_MAX)) begin
               state_nxt      = ST_SNOOZE;
               cnt_nxt        = '0;
               snooze_cnt_nxt = snooze_cnt + 2'd1;
            end else begin
               cnt_nxt = cnt + 30'd1;
            end
         end
         ST_SNOOZE: begin
            if (stop_key || cancel_wr) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == SNOOZE_LAST) begin
               state_nxt = ST_RING;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 30'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      led = 4'b0000;
      case (state)
         ST_RING:   led = 4'b1111;
         ST_SNOOZE: led = 4'b0001 << slot_sel;
         default:   led = 4'b0000;
      endcase
   end

   assign ring        = (state == ST_RING);
   assign busy        = (state == ST_RING) || (state == ST_SNOOZE);
   assign active_slot = slot_sel;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

   localparam int KEEP = 50;
   localparam int SNZ  = 20;
   localparam int MAXS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  sec_time, min_time, hour_time;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [23:0] wr_data;
   logic        wr_enable;
   logic        stop_key, snooze_key;
   logic [3:0]  led;
   logic        ring;
   logic [1:0]  active_slot;
   logic        busy;

   alarm_ctrl #(.KEEP_TIME(KEEP), .SNOOZE_TIME(SNZ), .MAX_SNOOZE(MAXS)) dut (
      .clk(clk), .reset(reset),
      .sec_time(sec_time), .min_time(min_time), .hour_time(hour_time),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
      .stop_key(stop_key), .snooze_key(snooze_key),
      .led(led), .ring(ring), .active_slot(active_slot), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model: event view with a remaining-cycles countdown.
   // m_mode: 0 quiet, 1 sounding, 2 paused.
   logic [23:0] m_time [4];
   logic [3:0]  m_en;
   logic [3:0]  m_hit_d;
   int          m_mode, m_slot, m_left, m_snz;

   task automatic model_step();
      logic [3:0] hit, trig;
      logic       cancel;
      int         first;
      if (reset) begin
         for (int i = 0; i < 4; i++) m_time[i] = '0;
         m_en = '0; m_hit_d = '0;
         m_mode = 0; m_slot = 0; m_left = 0; m_snz = 0;
         return;
      end
      for (int i = 0; i < 4; i++)
         hit[i] = m_en[i] && (m_time[i] == {hour_time, min_time, sec_time});
      trig   = hit & ~m_hit_d;
      cancel = wr_en && (int'(wr_addr) == m_slot);
      if (m_mode == 0) begin
         if (trig != 0) begin
            first = -1;
            for (int i = 0; i < 4; i++) if (trig[i] && first < 0) first = i;
            m_mode = 1; m_slot = first; m_left = KEEP; m_snz = 0;
         end
      end else if (m_mode == 1) begin
         if (stop_key || cancel) m_mode = 0;
         else if (m_left == 1) m_mode = 0;
         else if (snooze_key && m_snz < MAXS) begin
            m_mode = 2; m_left = SNZ; m_snz++;
         end else m_left--;
      end else begin
         if (stop_key || cancel) m_mode = 0;
         else if (m_left == 1) begin m_mode = 1; m_left = KEEP; end
         else m_left--;
      end
      m_hit_d = hit;
      if (wr_en) begin
         m_time[wr_addr] = wr_data;
         m_en[wr_addr]   = wr_enable;
      end
   endtask

   task automatic check(input string name, input logic [3:0] e_led, input logic e_ring,
                        input logic e_busy, input logic [1:0] e_slot);
      vectors++;
      if (led !== e_led || ring !== e_ring || busy !== e_busy || active_slot !== e_slot) begin
         errors++;
         $display("FAIL %s: got led=%b ring=%b busy=%b slot=%0d, expected led=%b ring=%b busy=%b slot=%0d",
                  name, led, ring, busy, active_slot, e_led, e_ring, e_busy, e_slot);
      end
   endtask

   task automatic tick();
      logic [3:0] e_led;
      model_step();
      @(posedge clk);
      #1;
      e_led = (m_mode == 1) ? 4'b1111 : (m_mode == 2) ? 4'(1 << m_slot) : 4'b0000;
      check("model", e_led, m_mode == 1, m_mode != 0, 2'(m_slot));
   endtask

   task automatic set_time(input logic [23:0] t);
      {hour_time, min_time, sec_time} = t;
   endtask

   task automatic clear_strobes();
      wr_en = 0; stop_key = 0; snooze_key = 0;
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  addr;
      logic [23:0] data;
      logic        en;
      logic [23:0] now;
      logic        stop;
      logic        snz;
      int          hold;
      logic [3:0]  e_led;
      logic        e_ring;
      logic        e_busy;
      logic [1:0]  e_slot;
   } vec_t;

   vec_t tab[$];

   task automatic add(input string name, input logic we, input logic [1:0] addr,
                      input logic [23:0] data, input logic en, input logic [23:0] now,
                      input logic stop, input logic snz, input int hold,
                      input logic [3:0] e_led, input logic e_ring, input logic e_busy,
                      input logic [1:0] e_slot);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.data = data; v.en = en; v.now = now;
      v.stop = stop; v.snz = snz; v.hold = hold;
      v.e_led = e_led; v.e_ring = e_ring; v.e_busy = e_busy; v.e_slot = e_slot;
      tab.push_back(v);
   endtask

   function automatic logic [23:0] pick_time();
      case ($urandom_range(0, 3))
         0: return 24'h123000;
         1: return 24'h070000;
         2: return 24'h083000;
         default: return 24'h000001;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold_left;
      reset = 1; clear_strobes(); wr_addr = 0; wr_data = 0; wr_enable = 0;
      set_time(24'h000000);
      #1;
      check("reset_async", 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); tick();
      check("reset_state", 4'b0000, 1'b0, 1'b0, 2'd0);
      reset = 0;

      //   name                 we addr data        en now         st sz hold led    rg bs slot
      add("wr_slot1",           1, 1, 24'h123000, 1, 24'h115959, 0, 0, 0,   4'h0, 0, 0, 0);
      add("ring_start",         0, 0, 24'h0,      0, 24'h123000, 0, 0, 0,   4'hf, 1, 1, 1);
      add("ring_cnt49",         0, 0, 24'h0,      0, 24'h123000, 0, 0, 48,  4'hf, 1, 1, 1);
      add("ring_timeout",       0, 0, 24'h0,      0, 24'h123000, 0, 0, 0,   4'h0, 0, 0, 1);
      add("no_retrigger",       0, 0, 24'h0,      0, 24'h123000, 0, 0, 150, 4'h0, 0, 0, 1);
      add("wr_slot0",           1, 0, 24'h070000, 1, 24'h123000, 0, 0, 0,   4'h0, 0, 0, 1);
      add("wr_slot2",           1, 2, 24'h070000, 1, 24'h123000, 0, 0, 0,   4'h0, 0, 0, 1);
      add("dual_match_low",     0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("stop",               0, 0, 24'h0,      0, 24'h070000, 1, 0, 0,   4'h0, 0, 0, 0);
      add("single_event",       0, 0, 24'h0,      0, 24'h070000, 0, 0, 10,  4'h0, 0, 0, 0);
      add("leave",              0, 0, 24'h0,      0, 24'h000001, 0, 0, 0,   4'h0, 0, 0, 0);
      add("ring2",              0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("ring_cnt10",         0, 0, 24'h0,      0, 24'h070000, 0, 0, 9,   4'hf, 1, 1, 0);
      add("snooze1",            0, 0, 24'h0,      0, 24'h070000, 0, 1, 0,   4'h1, 0, 1, 0);
      add("snooze1_last",       0, 0, 24'h0,      0, 24'h070000, 0, 0, 18,  4'h1, 0, 1, 0);
      add("resume1",            0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("snooze2",            0, 0, 24'h0,      0, 24'h070000, 0, 1, 0,   4'h1, 0, 1, 0);
      add("resume2",            0, 0, 24'h0,      0, 24'h070000, 0, 0, 19,  4'hf, 1, 1, 0);
      add("snooze3_ignored",    0, 0, 24'h0,      0, 24'h070000, 0, 1, 0,   4'hf, 1, 1, 0);
      add("ring_restart_cnt49", 0, 0, 24'h0,      0, 24'h070000, 0, 0, 47,  4'hf, 1, 1, 0);
      add("timeout2",           0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'h0, 0, 0, 0);
      add("leave2",             0, 0, 24'h0,      0, 24'h000001, 0, 0, 0,   4'h0, 0, 0, 0);
      add("ring3",              0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("stop_and_snooze",    0, 0, 24'h0,      0, 24'h070000, 1, 1, 0,   4'h0, 0, 0, 0);
      add("wr_slot3",           1, 3, 24'h083000, 1, 24'h000001, 0, 0, 0,   4'h0, 0, 0, 0);
      add("ring_slot3",         0, 0, 24'h0,      0, 24'h083000, 0, 0, 0,   4'hf, 1, 1, 3);
      add("wr_active_disable",  1, 3, 24'h083000, 0, 24'h083000, 0, 0, 0,   4'h0, 0, 0, 3);
      add("leave3",             0, 0, 24'h0,      0, 24'h000001, 0, 0, 0,   4'h0, 0, 0, 3);
      add("slot3_disabled",     0, 0, 24'h0,      0, 24'h083000, 0, 0, 5,   4'h0, 0, 0, 3);
      add("leave4",             0, 0, 24'h0,      0, 24'h000001, 0, 0, 0,   4'h0, 0, 0, 3);
      add("ring_slot0",         0, 0, 24'h0,      0, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("wr_other_slot",      1, 1, 24'h123000, 1, 24'h070000, 0, 0, 0,   4'hf, 1, 1, 0);
      add("stop4",              0, 0, 24'h0,      0, 24'h070000, 1, 0, 0,   4'h0, 0, 0, 0);

      foreach (tab[r]) begin
         wr_en = tab[r].we; wr_addr = tab[r].addr; wr_data = tab[r].data;
         wr_enable = tab[r].en; stop_key = tab[r].stop; snooze_key = tab[r].snz;
         set_time(tab[r].now);
         tick();
         clear_strobes();
         repeat (tab[r].hold) tick();
         check(tab[r].name, tab[r].e_led, tab[r].e_ring, tab[r].e_busy, tab[r].e_slot);
      end

      // Reset in the middle of a snooze while the time keeps matching.
      set_time(24'h000001); tick();
      set_time(24'h070000); tick();
      check("pre_reset_ring", 4'hf, 1'b1, 1'b1, 2'd0);
      snooze_key = 1; tick(); clear_strobes();
      repeat (5) tick();
      check("pre_reset_snooze", 4'h1, 1'b0, 1'b1, 2'd0);
      #2 reset = 1;
      #1 check("reset_mid_snooze", 4'h0, 1'b0, 1'b0, 2'd0);
      tick(); tick();
      reset = 0;
      repeat (60) tick();
      check("post_reset_quiet", 4'h0, 1'b0, 1'b0, 2'd0);
      set_time(24'h000001);
      wr_en = 1; wr_addr = 0; wr_data = 24'h070000; wr_enable = 1;
      tick(); clear_strobes();
      set_time(24'h070000); tick();
      check("rearm_after_reset", 4'hf, 1'b1, 1'b1, 2'd0);

      // Randomized traffic against the model.
      hold_left = 0;
      for (int c = 0; c < 4000; c++) begin
         clear_strobes();
         reset = 0;
         if (hold_left == 0) begin
            set_time(pick_time());
            hold_left = $urandom_range(1, 70);
         end
         hold_left--;
         if ($urandom_range(0, 24) == 0) begin
            wr_en = 1;
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = pick_time();
            wr_enable = ($urandom_range(0, 3) != 0);
         end
         stop_key   = ($urandom_range(0, 79) == 0);
         snooze_key = ($urandom_range(0, 11) == 0);
         reset      = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 0;
      clear_strobes();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter KEEP_TIME, default 50, ring duration in clk cycles.
REQ-002 Parameter SNOOZE_TIME, default 20, snooze duration in clk cycles.
REQ-003 Parameter MAX_SNOOZE, default 2, snoozes allowed per alarm event.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sec_time, min_time, hour_time  input  8 each  current time, BCD.
REQ-007 wr_en  input  1  one-cycle slot write strobe.
REQ-008 wr_addr  input  2  slot index 0..3.
REQ-009 wr_data  input  24  {hour, min, sec} BCD alarm time.
REQ-010 wr_enable  input  1  slot enable bit written with wr_data.
REQ-011 stop_key  input  1  one-cycle pulse, cancel alarm.
REQ-012 snooze_key  input  1  one-cycle pulse, snooze alarm.
REQ-013 led  output  4  alarm indicator.
REQ-014 ring  output  1  high while in RING.
REQ-015 active_slot  output  2  slot owning current event.
REQ-016 busy  output  1  high in RING or SNOOZE.

Function
REQ-017 Four slots, each 24-bit time plus enable bit; write updates slot wr_addr on the cycle after wr_en.
REQ-018 hit[i] = enable[i] AND stored time[i] == {hour_time,min_time,sec_time}; registered copy hit_d[i] updated every cycle.
REQ-019 trigger[i] = hit[i] AND NOT hit_d[i]; a time held equal for many cycles yields one trigger.
REQ-020 States IDLE, RING, SNOOZE; reset state IDLE.
REQ-021 IDLE: any trigger -> RING next cycle; active_slot = lowest-index triggering slot; cnt = 0; snooze_cnt = 0.
REQ-022 RING: cnt +1 per cycle; cnt == KEEP_TIME-1 -> IDLE, cnt = 0.
REQ-023 RING: stop_key -> IDLE; snooze_key with snooze_cnt < MAX_SNOOZE -> SNOOZE, cnt = 0, snooze_cnt +1.
REQ-024 RING: snooze_key with snooze_cnt == MAX_SNOOZE ignored; ringing continues.
REQ-025 SNOOZE: cnt +1 per cycle; cnt == SNOOZE_TIME-1 -> RING, cnt = 0; stop_key -> IDLE.
REQ-026 Priority within a cycle: stop_key > timeout > snooze_key.
REQ-027 Triggers arriving in RING or SNOOZE are dropped, not queued; hit_d still tracks.
REQ-028 Write to active_slot while busy -> IDLE next cycle, write still applied.
REQ-029 Same-cycle write and trigger: comparison uses pre-write slot contents.
REQ-030 led = 4'b1111 in RING; one-hot (1 << active_slot) in SNOOZE; 0 in IDLE.
REQ-031 cnt 30 bits; snooze_cnt 2 bits, never exceeds MAX_SNOOZE.

Reset
REQ-032 reset asserted: state IDLE, all slot times 0, all enables 0, hit_d 0, cnt 0, snooze_cnt 0, led 0, ring 0, busy 0, active_slot 0, independent of clk.
REQ-033 reset asserted mid-RING or mid-SNOOZE aborts the event; no trigger for a still-matching slot until hit falls and rises again after release.

Verification
REQ-034 Slot 1 = 12:30:00 enabled, time steps to 12:30:00 and holds 200 cycles -> ring and led=1111 from cycle after match for exactly 50 cycles, then led=0; no retrigger.
REQ-035 Slots 0 and 2 both = 07:00:00 enabled, time matches -> active_slot=0, single event.
REQ-036 Ringing, snooze_key at cnt=10 -> led=0001<<slot for 20 cycles, then ring again with cnt restarted at 0; third snooze_key ignored after two snoozes.
REQ-037 Ringing, stop_key and snooze_key same cycle -> IDLE, led=0, snooze_cnt unchanged.
REQ-038 Ringing slot 3, wr_en to slot 3 with wr_enable=0 -> IDLE next cycle, slot 3 disabled.
REQ-039 reset pulse during SNOOZE with time still matching -> all outputs 0; no ring until time leaves and re-enters match.
